tmds_symbol_decoder: RTL and testbench

Receive-side counterpart of the TMDS channel encoder. It takes one unaligned 10-bit parallel word per pixel clock from a deserializer and finds the 10-bit symbol boundary by searching for runs of control tokens. It then decodes each aligned symbol into 8-bit video data, a 2-bit control value, and a 4-bit TERC4 nibble, with validity flags. One instance sits per TMDS data channel in a future HDMI sink/loopback checker; period classification (video/data island/control) belongs to the consumer.

---
 rtl/tmds_pkg.sv | 35 +++
 rtl/tmds_symbol_lookup.sv | 45 ++++
 rtl/tmds_symbol_decoder.sv | 157 +++++++++++++++
 tb/tb_tmds_symbol_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, TERC4 code table, symbol type and alignment states.
// Used by both the encoder and decoder sides of the link.
package tmds_pkg;

    typedef logic [9:0] tmds_symbol_t;

    typedef enum logic {
        SEARCH,
        LOCKED
    } align_state_t;

    localparam tmds_symbol_t CTRL_TOKEN [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    localparam tmds_symbol_t TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    function automatic logic is_ctrl_token(input tmds_symbol_t sym);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sym == CTRL_TOKEN[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/tmds_symbol_lookup.sv
// Purely combinational decode of one aligned TMDS symbol into video data,
// control value and TERC4 nibble, each with a validity flag where applicable.
module tmds_symbol_lookup
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       ctrl_valid,
    output logic [3:0] terc4,
    output logic       terc4_valid
);

    logic [7:0] d;

    // Video decode undoes the optional inversion first, then the XOR/XNOR chain.
    always_comb begin
        d       = sym[9] ? ~sym[7:0] : sym[7:0];
        data    = '0;
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_comb begin
        ctrl        = '0;
        ctrl_valid  = 1'b0;
        terc4       = '0;
        terc4_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sym == CTRL_TOKEN[i]) begin
                ctrl       = 2'(i);
                ctrl_valid = 1'b1;
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (sym == TERC4_CODE[i]) begin
                terc4       = 4'(i);
                terc4_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmds_symbol_decoder.sv
// TMDS receive channel: finds the symbol boundary from control-token runs, then decodes symbols.
// Optional macro LOCK_STATS_EN adds a saturating count of lock losses on lock_losses.
module tmds_symbol_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN      = 8,
    parameter int SEARCH_WINDOW = 4096,
    parameter int LOCK_TIMEOUT  = 8192
) (
    input  logic       clk_pixel,
    input  logic       RST,
    input  logic [9:0] tmds_word,
    output logic       aligned,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       ctrl_valid,
    output logic [3:0] terc4,
    output logic       terc4_valid,
    output logic [3:0] bit_offset,
    output logic [7:0] lock_losses
);

    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int WIN_W = $clog2(SEARCH_WINDOW);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT);

    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(CTRL_RUN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

    align_state_t     state, state_next;
    logic [3:0]       offset, offset_next, offset_slip;
    logic [RUN_W-1:0] run_cnt, run_next;
    logic [WIN_W-1:0] win_cnt, win_next;
    logic [TO_W-1:0]  timeout_cnt, timeout_next;

    logic [9:0]   prev_word;
    tmds_symbol_t stage1_sym, sym_reg;
    logic [19:0]  window;
    logic         run_hit;

    logic [7:0] lut_data;
    logic [1:0] lut_ctrl;
    logic       lut_ctrl_valid;
    logic [3:0] lut_terc4;
    logic       lut_terc4_valid;

    assign window      = {tmds_word, prev_word};
    assign stage1_sym  = 10'(window >> offset);
    assign run_hit     = (run_cnt == RUN_MAX);
    assign offset_slip = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
    assign aligned     = (state == LOCKED);
    assign bit_offset  = offset;

    always_ff @(posedge clk_pixel or negedge RST) begin
        if (!RST) begin
            state       <= SEARCH;
            offset      <= '0;
            run_cnt     <= '0;
            win_cnt     <= '0;
            timeout_cnt <= '0;
            prev_word   <= '0;
            sym_reg     <= '0;
        end else begin
            state       <= state_next;
            offset      <= offset_next;
            run_cnt     <= run_next;
            win_cnt     <= win_next;
            timeout_cnt <= timeout_next;
            prev_word   <= tmds_word;
            sym_reg     <= stage1_sym;
        end
    end

    // Lock is checked before the slip so a run completing on the last window cycle keeps the offset.
    always_comb begin
        state_next   = state;
        offset_next  = offset;
        win_next     = win_cnt;
        timeout_next = timeout_cnt;
        if (is_ctrl_token(stage1_sym))
            run_next = run_hit ? run_cnt : run_cnt + 1'b1;
        else
            run_next = '0;

        case (state)
            SEARCH: begin
                win_next = win_cnt + 1'b1;
                if (run_hit) begin
                    state_next   = LOCKED;
                    win_next     = '0;
                    timeout_next = '0;
                end else if (win_cnt == WIN_LAST) begin
                    offset_next = offset_slip;
                    win_next    = '0;
                    run_next    = '0;
                end
            end
            LOCKED: begin
                timeout_next = timeout_cnt + 1'b1;
                if (run_hit) begin
                    timeout_next = '0;
                end else if (timeout_cnt == TO_LAST) begin
                    state_next   = SEARCH;
                    offset_next  = offset_slip;
                    win_next     = '0;
                    timeout_next = '0;
                    run_next     = '0;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    tmds_symbol_lookup u_lookup (
        .sym         (sym_reg),
        .data        (lut_data),
        .ctrl        (lut_ctrl),
        .ctrl_valid  (lut_ctrl_valid),
        .terc4       (lut_terc4),
        .terc4_valid (lut_terc4_valid)
    );

    always_ff @(posedge clk_pixel or negedge RST) begin
        if (!RST) begin
            data        <= '0;
            ctrl        <= '0;
            ctrl_valid  <= 1'b0;
            terc4       <= '0;
            terc4_valid <= 1'b0;
        end else begin
            data        <= lut_data;
            ctrl        <= lut_ctrl;
            ctrl_valid  <= lut_ctrl_valid;
            terc4       <= lut_terc4;
            terc4_valid <= lut_terc4_valid;
        end
    end

`ifdef LOCK_STATS_EN
    logic       lock_lost;
    logic [7:0] loss_cnt;

    assign lock_lost   = (state == LOCKED) && (state_next == SEARCH);
    assign lock_losses = loss_cnt;

    always_ff @(posedge clk_pixel or negedge RST) begin
        if (!RST)
            loss_cnt <= '0;
        else if (lock_lost && loss_cnt != 8'hFF)
            loss_cnt <= loss_cnt + 8'd1;
    end
`else
    assign lock_losses = '0;
`endif

endmodule

// File: tb/tb_tmds_symbol_decoder.sv
// Directed bench for tmds_symbol_decoder: alignment search, decode tables, lock timeout, wrap, async reset.
module tb_tmds_symbol_decoder;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;

    logic       clk_pixel;
    logic       RST;
    logic [9:0] tmds_word;
    logic       aligned;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       ctrl_valid;
    logic [3:0] terc4;
    logic       terc4_valid;
    logic [3:0] bit_offset;
    logic [7:0] lock_losses;

    int compared   = 0;
    int mismatched = 0;
    int delay      = 0;
    logic [9:0] last_sym = '0;

`ifdef LOCK_STATS_EN
    localparam logic [7:0] LOSSES_AFTER_TIMEOUT = 8'd1;
`else
    localparam logic [7:0] LOSSES_AFTER_TIMEOUT = 8'd0;
`endif

    tmds_symbol_decoder #(
        .CTRL_RUN      (8),
        .SEARCH_WINDOW (64),
        .LOCK_TIMEOUT  (256)
    ) dut (
        .clk_pixel   (clk_pixel),
        .RST         (RST),
        .tmds_word   (tmds_word),
        .aligned     (aligned),
        .data        (data),
        .ctrl        (ctrl),
        .ctrl_valid  (ctrl_valid),
        .terc4       (terc4),
        .terc4_valid (terc4_valid),
        .bit_offset  (bit_offset),
        .lock_losses (lock_losses)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // Emulates a serial stream whose symbols arrive `delay` bits late relative to word boundaries.
    task automatic apply_stimulus(input logic [9:0] s);
        logic [19:0] pair;
        pair      = {s, last_sym};
        tmds_word = pair[(10 - delay) +: 10];
        last_sym  = s;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        tmds_word = '0;
        #3;
        compared++; if (aligned !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_aligned: got %0h want 0", aligned); end
        compared++; if (bit_offset !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_offset: got %0h want 0", bit_offset); end
        compared++; if (data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_data: got %0h want 0", data); end
        compared++; if (ctrl_valid !== 1'b0 || terc4_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valids: got %0h/%0h want 0/0", ctrl_valid, terc4_valid); end
        compared++; if (lock_losses !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_losses: got %0h want 0", lock_losses); end
        repeat (2) @(posedge clk_pixel);
        #1;
        RST = 1'b1;
    endtask

    task automatic test_lock_search;
        int n;
        delay = 3;
        n = 0;
        while (aligned !== 1'b1 && n < 1000) begin
            apply_stimulus(C00);
            n++;
        end
        compared++; if (aligned !== 1'b1) begin mismatched++; $display("[TB] FAIL lock_search_aligned: got %0h want 1 after %0d cycles", aligned, n); end
        compared++; if (bit_offset !== 4'd3) begin mismatched++; $display("[TB] FAIL lock_search_offset: got %0d want 3", bit_offset); end
        repeat (4) apply_stimulus(C00);
        compared++; if (ctrl_valid !== 1'b1 || ctrl !== 2'd0) begin mismatched++; $display("[TB] FAIL lock_ctrl00: got valid %0h ctrl %0h want 1/0", ctrl_valid, ctrl); end
        compared++; if (terc4_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL lock_terc4_valid: got %0h want 0", terc4_valid); end
    endtask

    task automatic test_ctrl_values;
        logic [9:0] seq [5];
        logic [1:0] exp_ctrl [3];
        seq      = '{C01, C10, C11, C00, C00};
        exp_ctrl = '{2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(seq[i]);
            if (i >= 2) begin
                compared++;
                if (ctrl !== exp_ctrl[i-2] || ctrl_valid !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL ctrl_value[%0d]: got ctrl %0h valid %0h want %0h/1", i - 2, ctrl, ctrl_valid, exp_ctrl[i-2]);
                end
            end
        end
        repeat (10) apply_stimulus(C00);
    endtask

    task automatic test_video;
        logic [9:0] seq [5];
        logic [7:0] exp_data [3];
        seq      = '{10'h100, 10'h136, 10'h200, C00, C00};
        exp_data = '{8'h00, 8'h5A, 8'hFF};
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(seq[i]);
            if (i >= 2) begin
                compared++;
                if (data !== exp_data[i-2] || ctrl_valid !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL video[%0d]: got data %0h ctrl_valid %0h want %0h/0", i - 2, data, ctrl_valid, exp_data[i-2]);
                end
            end
        end
        repeat (12) apply_stimulus(C00);
        compared++; if (aligned !== 1'b1) begin mismatched++; $display("[TB] FAIL video_still_locked: got %0h want 1", aligned); end
    endtask

    task automatic test_terc4;
        logic [9:0] seq [19];
        seq = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011,
                10'b0111000011, C00, C00};
        for (int i = 0; i < 19; i++) begin
            apply_stimulus(seq[i]);
            if (i >= 2 && i < 18) begin
                compared++;
                if (terc4 !== 4'(i - 2) || terc4_valid !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL terc4[%0d]: got %0h valid %0h want %0h/1", i - 2, terc4, terc4_valid, i - 2);
                end
            end else if (i == 18) begin
                compared++;
                if (terc4_valid !== 1'b0 || terc4 !== 4'd0) begin
                    mismatched++;
                    $display("[TB] FAIL terc4_invalid: got %0h valid %0h want 0/0", terc4, terc4_valid);
                end
            end
        end
        repeat (12) apply_stimulus(C00);
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(10'h100);
            if (i == 249) begin
                compared++;
                if (aligned !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_early: got aligned %0h want 1", aligned); end
            end
            if (i == 265) begin
                compared++;
                if (aligned !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_drop: got aligned %0h want 0", aligned); end
            end
        end
        compared++; if (bit_offset !== 4'd4) begin mismatched++; $display("[TB] FAIL timeout_offset: got %0d want 4", bit_offset); end
        compared++; if (lock_losses !== LOSSES_AFTER_TIMEOUT) begin mismatched++; $display("[TB] FAIL timeout_losses: got %0d want %0d", lock_losses, LOSSES_AFTER_TIMEOUT); end
    endtask

    task automatic test_offset_wrap;
        int  n;
        logic seen9;
        delay = 0;
        seen9 = 1'b0;
        n = 0;
        while (aligned !== 1'b1 && n < 1500) begin
            apply_stimulus(C00);
            if (bit_offset == 4'd9) seen9 = 1'b1;
            n++;
        end
        compared++; if (seen9 !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_seen9: got %0h want 1", seen9); end
        compared++; if (aligned !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_aligned: got %0h want 1 after %0d cycles", aligned, n); end
        compared++; if (bit_offset !== 4'd0) begin mismatched++; $display("[TB] FAIL wrap_offset: got %0d want 0", bit_offset); end
        repeat (3) apply_stimulus(C00);
        compared++; if (ctrl_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_ctrl_valid: got %0h want 1", ctrl_valid); end
    endtask

    task automatic test_async_reset;
        int n;
        delay = 7;
        n = 0;
        while (bit_offset !== 4'd5 && n < 2000) begin
            apply_stimulus(C00);
            n++;
        end
        compared++; if (bit_offset !== 4'd5) begin mismatched++; $display("[TB] FAIL areset_reach5: got %0d want 5", bit_offset); end
        repeat (5) apply_stimulus(C00);
        #2;
        RST = 1'b0;
        #1;
        compared++; if (bit_offset !== 4'd0) begin mismatched++; $display("[TB] FAIL areset_offset: got %0d want 0", bit_offset); end
        compared++; if (aligned !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_aligned: got %0h want 0", aligned); end
        compared++; if (data !== 8'h00 || ctrl !== 2'd0 || terc4 !== 4'd0) begin mismatched++; $display("[TB] FAIL areset_outputs: got data %0h ctrl %0h terc4 %0h want 0/0/0", data, ctrl, terc4); end
        compared++; if (ctrl_valid !== 1'b0 || terc4_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_valids: got %0h/%0h want 0/0", ctrl_valid, terc4_valid); end
        compared++; if (lock_losses !== 8'd0) begin mismatched++; $display("[TB] FAIL areset_losses: got %0d want 0", lock_losses); end
        @(posedge clk_pixel);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        RST = 1'b0;
        tmds_word = '0;
        test_reset;
        test_lock_search;
        test_ctrl_values;
        test_video;
        test_terc4;
        test_timeout;
        test_offset_wrap;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
